// File: rtl/nonce_q_pkg.sv
// Shared types and widths for the golden-nonce transmit queue.
// Used by nonce_fifo_mem and nonce_tx_queue.
package nonce_q_pkg;

  localparam int NONCE_W = 32;
  localparam int OVF_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } drain_e;

  function automatic logic [OVF_W-1:0] sat_inc(
    input logic [OVF_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nonce_fifo_mem.sv
// Nonce FIFO storage: wrapping pointers, explicit level, registered full.
// Flush collapses the write pointer onto the read pointer.
module nonce_fifo_mem
  import nonce_q_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [NONCE_W-1:0]    wdata_i,
  output logic [NONCE_W-1:0]    rdata_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [NONCE_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  full_q, full_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = rptr_q;
      level_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    full_d = (level_d == LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  // Contents need no reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/nonce_tx_queue.sv
// Queues golden nonces from hub_core and drains them to serial_transmit.
// Optional NONCE_DEDUP_EN drops a strobe repeating the last accepted nonce.
module nonce_tx_queue
  import nonce_q_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NONCE_W-1:0]  in_nonce,
  input  logic                in_send,
  output logic                in_busy,
  input  logic                flush,
  output logic [NONCE_W-1:0]  tx_word,
  output logic                tx_send,
  input  logic                tx_busy,
  output logic [DEPTH_LOG2:0] level,
  output logic [OVF_W-1:0]    overflow_cnt
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  drain_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NONCE_W-1:0] word_q, word_d;
  logic               skip_q, skip_d;
  logic [OVF_W-1:0]   ovf_q;

  logic               full, empty, push, pop, dup, ovf_hit;
  logic [NONCE_W-1:0] head;

`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_q;
  logic               last_vld_q;

  assign dup = last_vld_q && (in_nonce == last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (flush) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= in_nonce;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop frees the slot the same cycle, so a full queue still accepts.
  assign pop     = (state_q == WAIT_DONE) && !tx_busy && !skip_q && !flush;
  assign push    = in_send && !flush && !dup && (!full || pop);
  assign ovf_hit = in_send && !flush && !dup && full && !pop;

  nonce_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (in_nonce),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    word_d  = word_q;
    skip_d  = skip_q;
    tx_send = 1'b0;
    unique case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (!empty && !tx_busy && !flush) begin
          word_d  = head;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_send = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The in-flight word left the queue with the flush; never pop it.
    if (flush && state_q != IDLE) skip_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      word_q  <= '0;
      skip_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      word_q  <= word_d;
      skip_q  <= skip_d;
      if (ovf_hit) ovf_q <= sat_inc(ovf_q);
    end
  end

  assign tx_word      = word_q;
  assign in_busy      = full;
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/nonce_tx_queue.md
Name: nonce_tx_queue

Overview:
- Buffers golden nonces between hub_core and serial_transmit.
- Accepts a 32-bit nonce on a one-cycle strobe from the hub.
- Queues nonces in a small FIFO so nonces found close together are not lost while the UART is busy.
- Drains the FIFO one word at a time to serial_transmit using its send/busy handshake.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8).
- ACK_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_send before retrying the same word.

Ports:
- clk  input  1  single clock (dv_clk domain).
- reset  input  1  asynchronous, active-high; clears all state.
- in_nonce  input  32  nonce from hub_core (golden_nonce).
- in_send  input  1  one-cycle strobe: in_nonce valid (hub serial_send).
- in_busy  output  1  high when FIFO full; fed back to hub as its serial_busy.
- flush  input  1  synchronous clear of queued, not-yet-sent words.
- tx_word  output  32  word presented to serial_transmit.
- tx_send  output  1  one-cycle send pulse to serial_transmit.
- tx_busy  input  1  serial_transmit busy.
- level  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow_cnt  output  8  saturating count of nonces dropped because the FIFO was full.

Behaviour:
- Reset values:
  - FIFO empty, level=0, in_busy=0.
  - tx_send=0, tx_word=0, overflow_cnt=0.
  - State IDLE.
- Push:
  - in_send=1 and FIFO not full: write in_nonce at the write pointer; level increments on the next edge.
  - in_send=1 and FIFO full: drop the word; overflow_cnt increments and saturates at 255.
  - Exception: if a pop occurs in the same cycle, the push is accepted.
- in_busy is registered: in_busy = (level == 2**DEPTH_LOG2).
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level is tracked separately.
- Drain FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: if level>0 and tx_busy=0, latch head word into tx_word; go to SEND.
  - SEND: tx_send=1 for exactly this cycle; go to WAIT_ACK with timer=0.
  - WAIT_ACK: if tx_busy=1, go to WAIT_DONE. Otherwise the timer increments. When timer==ACK_TIMEOUT, return to IDLE without popping, so the same word is resent.
  - WAIT_DONE: when tx_busy falls to 0, pop the head (read pointer +1, level −1); go to IDLE.
- tx_word stays stable from SEND until the pop.
- Minimum spacing between sends is 3 cycles plus the UART busy time.
- Latency: a push into an empty queue with tx_busy=0 produces tx_send on the 2nd edge after the in_send edge (registered write, then IDLE→SEND).
- Simultaneous push and pop: level unchanged, both pointers advance.
- Flush:
  - Sets write pointer = read pointer, level=0, in_busy=0.
  - If asserted in WAIT_ACK or WAIT_DONE, the in-flight word finishes its handshake but is not popped a second time (level stays 0). The FSM then returns to IDLE.
  - A flush in the same cycle as in_send discards the incoming word without counting it as overflow.
- Reset mid-transfer: the FSM drops to IDLE and tx_send goes 0 immediately. The downstream transmitter is not aborted.

Optional Feature:
- Macro NONCE_DEDUP_EN.
- Defined:
  - Keep a 32-bit last_accepted register plus a valid bit; both are cleared by reset and flush.
  - An in_send whose in_nonce equals last_accepted is discarded silently: no push, no overflow count.
  - Only words actually accepted update last_accepted.
- Undefined: every strobe is queued; no compare logic is built.

Decomposition:
- Shared package nonce_q_pkg:
  - NONCE_W=32.
  - Drain-state encoding: IDLE=2'd0, SEND=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3.
  - OVF_W=8.
- One sub-module nonce_fifo_mem holds storage, pointers, level and full/empty. The top holds the drain FSM, overflow counter and dedup logic.

Test Plan:
- Single nonce: push 0xDEADBEEF with tx_busy=0.
  - tx_send pulses once, 2 edges later, with tx_word=0xDEADBEEF.
  - Bench model raises busy for 20 cycles; level returns to 0 after busy falls.
- Burst: push 0x1, 0x2, 0x3 on consecutive cycles while tx_busy=1.
  - level=3.
  - Sends go out in order 1, 2, 3, each only after busy drops.
- Overflow: with tx_busy held 1, push 10 words into the 8-deep FIFO.
  - in_busy=1 after the 8th push; overflow_cnt=2.
  - Words 9–10 are never sent.
  - Push 300 more words: overflow_cnt saturates at 255.
- Ack timeout: tx_busy stuck 0 after tx_send.
  - After 15 cycles the same word is resent; level unchanged.
- Flush/reset: queue 5 words, assert flush during WAIT_DONE.
  - The in-flight word completes; level=0; no further sends.
  - Assert reset mid-SEND: tx_send drops immediately and all outputs return to reset values.
- NONCE_DEDUP_EN: push 0xA, 0xA, 0xB, 0xA.
  - Exactly 3 words sent (A, B, A); overflow_cnt=0.
